// File: rtl/instr_reg_ctrl.sv
// Write-arbitration, pointer and occupancy controller that turns instr_register into a
// DEPTH-entry instruction queue shared by two requesters, with a zero-fill CLEAR sequence.
module instr_reg_ctrl #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned OPND_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // requester A
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [OPC_W-1:0]  a_opcode,
    input  logic [OPND_W-1:0] a_operand_a,
    input  logic [OPND_W-1:0] a_operand_b,
    // requester B
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [OPC_W-1:0]  b_opcode,
    input  logic [OPND_W-1:0] b_operand_a,
    input  logic [OPND_W-1:0] b_operand_b,
    // instr_register write/read port
    output logic              load_en,
    output logic [OPC_W-1:0]  opcode,
    output logic [OPND_W-1:0] operand_a,
    output logic [OPND_W-1:0] operand_b,
    output logic [AW-1:0]     write_pointer,
    output logic [AW-1:0]     read_pointer,
    // consumer
    output logic              rd_valid,
    input  logic              rd_ready,
    // clear sequence
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    // occupancy
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    localparam logic [AW-1:0] LastIdx   = AW'(DEPTH - 1);
    localparam logic [AW:0]   FullCount = (AW + 1)'(DEPTH);

    typedef enum logic {
        StRun,
        StClear
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            last_grant_q, last_grant_d;  // 1: B was granted last
    logic            clear_done_q, clear_done_d;

    logic            grant_a;
    logic            grant_b;
    logic            rd_fire;

    assign full          = (count_q == FullCount);
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign write_pointer = wr_ptr_q;
    assign read_pointer  = rd_ptr_q;
    assign clear_busy    = (state_q == StClear);
    assign clear_done    = clear_done_q;
    assign rd_valid      = !empty && (state_q == StRun);
    assign rd_fire       = rd_valid && rd_ready;
    assign a_ready       = grant_a;
    assign b_ready       = grant_b;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        clear_done_d = 1'b0;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        load_en      = 1'b0;
        opcode       = '0;
        operand_a    = '0;
        operand_b    = '0;

        unique case (state_q)
            StRun: begin
                // Full blocks writes regardless of a same-cycle read: no bypass.
                if (!full && !clear_req) begin
                    if (a_valid && b_valid) begin
                        grant_a = last_grant_q;
                        grant_b = !last_grant_q;
                    end else begin
                        grant_a = a_valid;
                        grant_b = b_valid;
                    end
                end

                load_en = grant_a || grant_b;
                if (grant_a) begin
                    opcode    = a_opcode;
                    operand_a = a_operand_a;
                    operand_b = a_operand_b;
                end else if (grant_b) begin
                    opcode    = b_opcode;
                    operand_a = b_operand_a;
                    operand_b = b_operand_b;
                end

                if (load_en) begin
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    last_grant_d = grant_b;
                end
                if (rd_fire) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end

                case ({load_en, rd_fire})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase

                // The write pointer doubles as the clear index, so it restarts at 0.
                if (clear_req) begin
                    state_d  = StClear;
                    wr_ptr_d = '0;
                end
            end

            StClear: begin
                load_en  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == LastIdx) begin
                    state_d      = StRun;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    count_d      = '0;
                    clear_done_d = 1'b1;
                end
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            clear_done_q <= clear_done_d;
        end
    end

endmodule
